// File: rtl/clock_divider_bank.sv
// Multi-channel runtime-programmable clock divider with glitch-free ratio updates.
// Optional CFG_SYNC_EN adds a sync input that phase-aligns every channel.
module clock_divider_bank #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick
`ifdef CFG_SYNC_EN
  ,
  input  logic              sync
`endif
);

  // Handshake: a request transfers on a rising edge where cfg_valid && cfg_ready.
  // cfg_ready drops only while the addressed channel already holds a pending
  // ratio; a transferred request with an illegal channel or divisor is dropped
  // and flagged by a one-cycle cfg_err pulse.

  logic [CNT_W-1:0]  r_div  [NUM_CH];
  logic [CNT_W-1:0]  r_cnt  [NUM_CH];
  logic [CNT_W-1:0]  r_pdiv [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_div_out;
  logic [NUM_CH-1:0] r_tick;
  logic              r_err;

  logic              w_sync;
  logic              w_sel_pend;
  logic              w_ch_ok;
  logic              w_legal;
  logic              w_fire;
  logic              w_accept;
  logic [CNT_W-1:0]  w_div_n [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_n [NUM_CH];
  logic [CNT_W-1:0]  w_hi    [NUM_CH];
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_apply;
  logic [NUM_CH-1:0] w_out_n;
  logic [NUM_CH-1:0] w_tick_n;
  logic [NUM_CH-1:0] w_load;

  // Default ratio 2<<k, clamped to the widest divisor the counter can hold.
  function automatic logic [CNT_W-1:0] reset_div(input int k);
    longint v;
    longint v_max;
    v_max = (longint'(1) << CNT_W) - 1;
    v     = longint'(2) << k;
    if (v > v_max) v = v_max;
    return v[CNT_W-1:0];
  endfunction

`ifdef CFG_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  always_comb begin
    w_sel_pend = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (32'(cfg_ch) == k) w_sel_pend = r_pend[k];
    end
  end

  assign w_ch_ok   = (32'(cfg_ch) < NUM_CH);
  assign w_legal   = w_ch_ok && (cfg_div >= CNT_W'(2));
  assign cfg_ready = !w_sel_pend;
  assign w_fire    = cfg_valid && cfg_ready;
  assign w_accept  = w_fire && w_legal;

  always_comb begin
    w_div_n  = '{default: '0};
    w_cnt_n  = '{default: '0};
    w_hi     = '{default: '0};
    w_wrap   = '0;
    w_apply  = '0;
    w_out_n  = '0;
    w_tick_n = '0;
    w_load   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_wrap[k]   = (r_cnt[k] == r_div[k] - CNT_W'(1));
      // A pending ratio only lands on a period boundary (or a sync), never mid-period.
      w_apply[k]  = r_pend[k] && (w_wrap[k] || w_sync);
      w_div_n[k]  = w_apply[k] ? r_pdiv[k] : r_div[k];
      w_cnt_n[k]  = (w_wrap[k] || w_sync) ? '0 : r_cnt[k] + CNT_W'(1);
      w_hi[k]     = w_div_n[k] - (w_div_n[k] >> 1);
      w_out_n[k]  = (w_cnt_n[k] < w_hi[k]);
      w_tick_n[k] = (w_cnt_n[k] == '0);
      w_load[k]   = w_accept && (32'(cfg_ch) == k);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_div[k]  <= reset_div(k);
        r_cnt[k]  <= reset_div(k) - CNT_W'(1);
        r_pdiv[k] <= '0;
      end
      r_pend    <= '0;
      r_div_out <= '0;
      r_tick    <= '0;
      r_err     <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_div[k] <= w_div_n[k];
        r_cnt[k] <= w_cnt_n[k];
        // Load and apply are exclusive: a channel only accepts while not pending.
        if (w_load[k]) begin
          r_pend[k] <= 1'b1;
          r_pdiv[k] <= cfg_div;
        end else if (w_apply[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
      r_div_out <= w_out_n;
      r_tick    <= w_tick_n;
      r_err     <= w_fire && !w_legal;
    end
  end

  assign div_out = r_div_out;
  assign tick    = r_tick;
  assign cfg_err = r_err;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Randomized scoreboard bench for clock_divider_bank; the reference model builds
// each channel's waveform one whole period at a time.
module tb_clock_divider_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;
  localparam int W      = 2 * NUM_CH + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_err;
  logic [NUM_CH-1:0] div_out;
  logic [NUM_CH-1:0] tick;
`ifdef CFG_SYNC_EN
  logic              sync;
`endif

  always #5 clk = ~clk;

  clock_divider_bank #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .CH_W  (CH_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .div_out  (div_out),
    .tick     (tick)
`ifdef CFG_SYNC_EN
    ,
    .sync     (sync)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected {cfg_err, tick, div_out} for each clock edge.
  logic [W-1:0] exp_q[$];

  // Reference model state: current divisor, pending request, and the remaining
  // samples {tick, div_out} of the period in progress.
  int       m_d    [NUM_CH];
  int       m_pdiv [NUM_CH];
  bit       m_pend [NUM_CH];
  logic [1:0] m_wave [NUM_CH][$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin : model
    logic [W-1:0] e;
    logic [1:0]   s;
    bit           rdy;
    bit           ok;
    bit           sy;
    int           ch;
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_d[k]    = 2 << k;
        m_pdiv[k] = 0;
        m_pend[k] = 1'b0;
        m_wave[k].delete();
      end
      if (clk) exp_q.push_back('0);
    end else begin
      sy = 1'b0;
`ifdef CFG_SYNC_EN
      sy = sync;
`endif
      ch = int'(cfg_ch);
      ok = (ch < NUM_CH);
      rdy = 1'b1;
      if (ok) rdy = !m_pend[ch];
      e = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (sy || m_wave[k].size() == 0) begin
          if (m_pend[k]) begin
            m_d[k]    = m_pdiv[k];
            m_pend[k] = 1'b0;
          end
          m_wave[k].delete();
          for (int i = 0; i < m_d[k]; i++)
            m_wave[k].push_back({(i == 0), (i < (m_d[k] + 1) / 2)});
        end
      end
      if (cfg_valid && rdy) begin
        if (ok && int'(cfg_div) >= 2) begin
          m_pend[ch] = 1'b1;
          m_pdiv[ch] = int'(cfg_div);
        end else begin
          e[W-1] = 1'b1;
        end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        s = m_wave[k].pop_front();
        e[NUM_CH + k] = s[1];
        e[k]          = s[0];
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    logic [W-1:0] e;
    logic [W-1:0] er;
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        #1;
        check("reset_outputs", {cfg_err, tick, div_out}, '0);
        exp_q.delete();
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("outputs", {cfg_err, tick, div_out}, e);
        er = W'(1);
        if (int'(cfg_ch) < NUM_CH) er = W'(!m_pend[int'(cfg_ch)]);
        check("cfg_ready", W'(cfg_ready), er);
      end
    end
  end

  // All driver tasks start and end 2 time units after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input int ch, input int dv);
    bit r;
    bit done;
    cfg_ch    = CH_W'(ch);
    cfg_div   = CNT_W'(dv);
    cfg_valid = 1'b1;
    done      = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      r = cfg_ready;
      @(posedge clk);
      #2;
      done = r;
    end
    cfg_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL cfg_write_timeout: ch %0d div %0d never accepted within 600 cycles", ch, dv);
    end
  endtask

  task automatic reset_pulse();
    #4 reset = 1'b1;
    #3 reset = 1'b0;
    @(posedge clk);
    #2;
  endtask

`ifdef CFG_SYNC_EN
  task automatic sync_pulse();
    sync = 1'b1;
    @(posedge clk);
    #2;
    sync = 1'b0;
  endtask
`endif

  initial begin
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CFG_SYNC_EN
    sync      = 1'b0;
`endif
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Default ratios /2 /4 /8 after release.
    idle(24);

    // ch0 -> 5 mid-period, then two back-to-back writes on ch2.
    idle(1);
    cfg_write(0, 5);
    idle(20);
    cfg_write(2, 6);
    cfg_write(2, 3);
    idle(20);

    // Illegal divisors and channel index.
    cfg_write(0, 1);
    idle(2);
    cfg_write(3, 5);
    idle(2);
    cfg_write(1, 0);
    idle(3);

    // Reset while a ch1 request is pending.
    idle(1);
    cfg_write(1, 7);
    reset_pulse();
    idle(20);

    // Extreme divisors and rewriting the current ratio.
    cfg_write(1, 255);
    idle(10);
    cfg_write(1, 2);
    idle(270);
    cfg_write(0, 2);
    idle(10);

`ifdef CFG_SYNC_EN
    cfg_write(0, 2);
    cfg_write(1, 5);
    cfg_write(2, 8);
    idle(20);
    sync_pulse();
    idle(85);
`endif

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 7)
        cfg_write(int'($urandom_range(0, 4)), int'($urandom_range(0, 12)));
`ifdef CFG_SYNC_EN
      if ($urandom_range(0, 15) == 0) sync_pulse();
`endif
      idle(int'($urandom_range(0, 6)));
    end

    idle(20);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
